// File: rtl/vga_ball_array.sv
// VGA ball renderer: 1600x525 scan timing, per-ball disc test against double-buffered
// registers, lowest-index priority, and a fixed-latency pixel path with aligned sync outputs.
module vga_ball_array #(
  parameter int          NBALLS   = 4,
  parameter int          ADDR_W   = 4,
  parameter logic [23:0] BG_COLOR = 24'h000000,
  parameter int          PIPE     = 4,
  parameter int          H_ACTIVE = 1280,
  parameter int          H_FP     = 32,
  parameter int          H_SYNC   = 192,
  parameter int          H_BP     = 96,
  parameter int          V_ACTIVE = 480,
  parameter int          V_FP     = 10,
  parameter int          V_SYNC   = 2,
  parameter int          V_BP     = 33
) (
  input  logic              clk50,
  input  logic              reset,
  input  logic              chipselect,
  input  logic              write,
  input  logic [ADDR_W-1:0] address,
  input  logic [31:0]       writedata,
  output logic [7:0]        VGA_R,
  output logic [7:0]        VGA_G,
  output logic [7:0]        VGA_B,
  output logic              VGA_CLK,
  output logic              VGA_HS,
  output logic              VGA_VS,
  output logic              VGA_BLANK_n,
  output logic              VGA_SYNC_n,
  output logic              vblank_irq
);
  localparam logic [10:0] H_LAST = 11'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [10:0] H_ACT  = 11'(H_ACTIVE);
  localparam logic [10:0] HS_BEG = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] HS_END = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0]  V_LAST = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [9:0]  V_ACT  = 10'(V_ACTIVE);
  localparam logic [9:0]  VS_BEG = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0]  VS_END = 10'(V_ACTIVE + V_FP + V_SYNC);
  // Three compute stages (distance, hit, select); PIPE must be at least 4.
  localparam int XD = PIPE - 3;

  logic [10:0] hcount_q, hcount_d;
  logic [9:0]  vcount_q, vcount_d;

  logic [9:0]  st_hpos_q [NBALLS], st_hpos_d [NBALLS], dp_hpos_q [NBALLS], dp_hpos_d [NBALLS];
  logic [8:0]  st_vpos_q [NBALLS], st_vpos_d [NBALLS], dp_vpos_q [NBALLS], dp_vpos_d [NBALLS];
  logic [9:0]  st_rad_q  [NBALLS], st_rad_d  [NBALLS], dp_rad_q  [NBALLS], dp_rad_d  [NBALLS];
  logic [23:0] st_col_q  [NBALLS], st_col_d  [NBALLS], dp_col_q  [NBALLS], dp_col_d  [NBALLS];
  logic [NBALLS-1:0] st_en_q, st_en_d, dp_en_q, dp_en_d;

  logic [21:0] dist_q [NBALLS], dist_d [NBALLS], rsq_q [NBALLS], rsq_d [NBALLS];
  logic [NBALLS-1:0] en1_q, en1_d, hit_q, hit_d;
  logic [23:0] color_q, color_d;
  logic [23:0] cdly_q [XD], cdly_d [XD];
  logic [PIPE-1:0] blank_q, blank_d, hs_q, hs_d, vs_q, vs_d;

  logic [10:0] dxu [NBALLS], dyu [NBALLS], adx [NBALLS], ady [NBALLS];
  logic [9:0]  px;
  logic [8:0]  py;
  logic        we, copy, hs_now, vs_now, act_now;
  logic [ADDR_W-1:0] ball_sel;
  logic [1:0]  field;
  logic        unused_bits;

  assign unused_bits = ^writedata[31:25];

  always_comb begin
    hcount_d  = (hcount_q == H_LAST) ? 11'd0 : hcount_q + 11'd1;
    vcount_d  = vcount_q;
    if (hcount_q == H_LAST) vcount_d = (vcount_q == V_LAST) ? 10'd0 : vcount_q + 10'd1;
    px        = hcount_q[10:1];
    py        = vcount_q[8:0];
    copy      = (hcount_q == 11'd0) && (vcount_q == V_ACT);
    we        = chipselect & write;
    ball_sel  = address >> 2;
    field     = address[1:0];
    act_now   = (hcount_q < H_ACT) && (vcount_q < V_ACT);
    hs_now    = !((hcount_q >= HS_BEG) && (hcount_q < HS_END));
    vs_now    = !((vcount_q >= VS_BEG) && (vcount_q < VS_END));
    st_hpos_d = st_hpos_q;
    st_vpos_d = st_vpos_q;
    st_rad_d  = st_rad_q;
    st_col_d  = st_col_q;
    st_en_d   = st_en_q;
    dp_hpos_d = dp_hpos_q;
    dp_vpos_d = dp_vpos_q;
    dp_rad_d  = dp_rad_q;
    dp_col_d  = dp_col_q;
    dp_en_d   = dp_en_q;
    // The display set copies the pre-write staging value, so a copy-cycle write waits a frame.
    if (copy) begin
      dp_hpos_d = st_hpos_q;
      dp_vpos_d = st_vpos_q;
      dp_rad_d  = st_rad_q;
      dp_col_d  = st_col_q;
      dp_en_d   = st_en_q;
    end
    for (int i = 0; i < NBALLS; i++) begin
      if (we && (ball_sel == ADDR_W'(i))) begin
        case (field)
          2'd0: begin
            st_hpos_d[i] = writedata[9:0];
            st_vpos_d[i] = writedata[24:16];
          end
          2'd1:    st_rad_d[i] = writedata[9:0];
          2'd2:    st_col_d[i] = writedata[23:0];
          default: st_en_d[i]  = writedata[0];
        endcase
      end
      dxu[i]    = {1'b0, px} - {1'b0, dp_hpos_q[i]};
      dyu[i]    = {2'b0, py} - {2'b0, dp_vpos_q[i]};
      adx[i]    = dxu[i][10] ? (11'd0 - dxu[i]) : dxu[i];
      ady[i]    = dyu[i][10] ? (11'd0 - dyu[i]) : dyu[i];
      dist_d[i] = ({11'd0, adx[i]} * {11'd0, adx[i]}) + ({11'd0, ady[i]} * {11'd0, ady[i]});
      rsq_d[i]  = {12'd0, dp_rad_q[i]} * {12'd0, dp_rad_q[i]};
      hit_d[i]  = en1_q[i] && (dist_q[i] < rsq_q[i]);
    end
    en1_d   = dp_en_q;
    color_d = BG_COLOR;
    for (int i = NBALLS - 1; i >= 0; i--) begin
      if (hit_q[i]) color_d = dp_col_q[i];
    end
    cdly_d[0] = color_q;
    for (int k = 1; k < XD; k++) cdly_d[k] = cdly_q[k-1];
    blank_d = {blank_q[PIPE-2:0], act_now};
    hs_d    = {hs_q[PIPE-2:0], hs_now};
    vs_d    = {vs_q[PIPE-2:0], vs_now};
  end

  always_ff @(posedge clk50 or posedge reset) begin
    if (reset) begin
      hcount_q <= '0;
      vcount_q <= '0;
      for (int i = 0; i < NBALLS; i++) begin
        st_hpos_q[i] <= '0;
        st_vpos_q[i] <= '0;
        st_rad_q[i]  <= '0;
        st_col_q[i]  <= '0;
        dp_hpos_q[i] <= '0;
        dp_vpos_q[i] <= '0;
        dp_rad_q[i]  <= '0;
        dp_col_q[i]  <= '0;
        dist_q[i]    <= '0;
        rsq_q[i]     <= '0;
      end
      st_en_q <= '0;
      dp_en_q <= '0;
      en1_q   <= '0;
      hit_q   <= '0;
      color_q <= '0;
      for (int k = 0; k < XD; k++) cdly_q[k] <= '0;
      blank_q <= '0;
      hs_q    <= '1;
      vs_q    <= '1;
    end else begin
      hcount_q  <= hcount_d;
      vcount_q  <= vcount_d;
      st_hpos_q <= st_hpos_d;
      st_vpos_q <= st_vpos_d;
      st_rad_q  <= st_rad_d;
      st_col_q  <= st_col_d;
      st_en_q   <= st_en_d;
      dp_hpos_q <= dp_hpos_d;
      dp_vpos_q <= dp_vpos_d;
      dp_rad_q  <= dp_rad_d;
      dp_col_q  <= dp_col_d;
      dp_en_q   <= dp_en_d;
      dist_q    <= dist_d;
      rsq_q     <= rsq_d;
      en1_q     <= en1_d;
      hit_q     <= hit_d;
      color_q   <= color_d;
      cdly_q    <= cdly_d;
      blank_q   <= blank_d;
      hs_q      <= hs_d;
      vs_q      <= vs_d;
    end
  end

  assign {VGA_R, VGA_G, VGA_B} = blank_q[PIPE-1] ? cdly_q[XD-1] : 24'h000000;
  assign VGA_BLANK_n = blank_q[PIPE-1];
  assign VGA_HS      = hs_q[PIPE-1];
  assign VGA_VS      = vs_q[PIPE-1];
  assign VGA_CLK     = hcount_q[0];
  assign VGA_SYNC_n  = 1'b1;
  assign vblank_irq  = copy;
endmodule

// File: tb/tb_vga_ball_array.sv
// Bench for vga_ball_array: a reduced-timing instance for frame-level behaviour and a
// default-timing instance for the full-size horizontal line.
module tb_vga_ball_array;
  localparam int PIPE = 4;
  localparam int HA = 80, HF = 2, HSY = 8, HB = 6, HT = HA + HF + HSY + HB;
  localparam int VA = 48, VF = 2, VSY = 2, VB = 3, VT = VA + VF + VSY + VB;
  localparam int FRAME = HT * VT;
  localparam int FHT = 1600, FVT = 525;
  localparam logic [23:0] BG = 24'h102030;

  logic clk50 = 1'b0;
  always #10 clk50 = ~clk50;

  logic        reset = 1'b1;
  logic        cs = 1'b0, wr = 1'b0;
  logic [3:0]  addr = '0;
  logic [31:0] wdata = '0;

  logic [7:0]  r, g, b, f_r, f_g, f_b;
  logic        vclk, hs, vs, blank_n, sync_n, irq;
  logic        f_vclk, f_hs, f_vs, f_blank_n, f_sync_n, f_irq;
  logic [23:0] rgb, f_rgb;
  assign rgb   = {r, g, b};
  assign f_rgb = {f_r, f_g, f_b};

  vga_ball_array #(
    .NBALLS(3), .ADDR_W(4), .BG_COLOR(BG), .PIPE(PIPE),
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSY), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSY), .V_BP(VB)
  ) dut (
    .clk50(clk50), .reset(reset), .chipselect(cs), .write(wr), .address(addr),
    .writedata(wdata), .VGA_R(r), .VGA_G(g), .VGA_B(b), .VGA_CLK(vclk), .VGA_HS(hs),
    .VGA_VS(vs), .VGA_BLANK_n(blank_n), .VGA_SYNC_n(sync_n), .vblank_irq(irq)
  );

  vga_ball_array dut_full (
    .clk50(clk50), .reset(reset), .chipselect(1'b0), .write(1'b0), .address(4'd0),
    .writedata(32'd0), .VGA_R(f_r), .VGA_G(f_g), .VGA_B(f_b), .VGA_CLK(f_vclk), .VGA_HS(f_hs),
    .VGA_VS(f_vs), .VGA_BLANK_n(f_blank_n), .VGA_SYNC_n(f_sync_n), .vblank_irq(f_irq)
  );

  int n_cmp = 0, n_fail = 0;
  int h_m, v_m, hf_m, vf_m;

  // Reference scan position of each instance during the current cycle.
  always @(posedge clk50 or posedge reset) begin
    if (reset) begin
      h_m <= 0; v_m <= 0; hf_m <= 0; vf_m <= 0;
    end else begin
      if (h_m == HT - 1) begin
        h_m <= 0;
        v_m <= (v_m == VT - 1) ? 0 : v_m + 1;
      end else h_m <= h_m + 1;
      if (hf_m == FHT - 1) begin
        hf_m <= 0;
        vf_m <= (vf_m == FVT - 1) ? 0 : vf_m + 1;
      end else hf_m <= hf_m + 1;
    end
  end

  initial begin
    #(4_000_000);
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic wait_hv(input int h, input int v);
    int n = 0;
    @(negedge clk50);
    while (!(h_m == h && v_m == v) && n < 2 * FRAME) begin
      @(negedge clk50);
      n++;
    end
    if (n >= 2 * FRAME) begin
      n_cmp++; n_fail++;
      $display("FAIL wait_hv: position (%0d,%0d) not reached, required within %0d cycles", h, v, 2 * FRAME);
    end
  endtask

  task automatic wait_pixel(input int x, input int y);
    wait_hv(2 * x + PIPE, y);
  endtask

  task automatic wait_full(input int h);
    int n = 0;
    @(negedge clk50);
    while (!(hf_m == h && vf_m == 0) && n < 2 * FHT) begin
      @(negedge clk50);
      n++;
    end
    if (n >= 2 * FHT) begin
      n_cmp++; n_fail++;
      $display("FAIL wait_full: hcount %0d not reached", h);
    end
  endtask

  task automatic wait_irq();
    int n = 0;
    @(negedge clk50);
    while (irq !== 1'b1 && n < 2 * FRAME) begin
      @(negedge clk50);
      n++;
    end
    if (n >= 2 * FRAME) begin
      n_cmp++; n_fail++;
      $display("FAIL wait_irq: vblank_irq=%b, required a pulse within %0d cycles", irq, 2 * FRAME);
    end
  endtask

  // Caller is at a negedge; the write is sampled on the following posedge.
  task automatic write_reg(input int ball, input int fld, input logic [31:0] data);
    cs = 1'b1; wr = 1'b1; addr = 4'(ball * 4 + fld); wdata = data;
    @(negedge clk50);
    cs = 1'b0; wr = 1'b0;
  endtask

  task automatic set_ball(input int ball, input int x, input int y, input int rad,
                          input logic [23:0] col, input logic en);
    @(negedge clk50);
    write_reg(ball, 0, {7'd0, 9'(y), 6'd0, 10'(x)});
    write_reg(ball, 1, {22'd0, 10'(rad)});
    write_reg(ball, 2, {8'd0, col});
    write_reg(ball, 3, {31'd0, en});
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk50);
    n_cmp++; if (rgb !== 24'h0) begin n_fail++; $display("FAIL reset_rgb: got %h want %h", rgb, 24'h0); end
    n_cmp++; if (hs !== 1'b1) begin n_fail++; $display("FAIL reset_hs: got %b want 1", hs); end
    n_cmp++; if (vs !== 1'b1) begin n_fail++; $display("FAIL reset_vs: got %b want 1", vs); end
    n_cmp++; if (blank_n !== 1'b0) begin n_fail++; $display("FAIL reset_blank: got %b want 0", blank_n); end
    n_cmp++; if (sync_n !== 1'b1) begin n_fail++; $display("FAIL reset_sync: got %b want 1", sync_n); end
    n_cmp++; if (irq !== 1'b0) begin n_fail++; $display("FAIL reset_irq: got %b want 0", irq); end
    n_cmp++; if (f_hs !== 1'b1 || f_vs !== 1'b1 || f_blank_n !== 1'b0 || f_rgb !== 24'h0)
      begin n_fail++; $display("FAIL reset_full: hs=%b vs=%b blank=%b rgb=%h want 1 1 0 000000", f_hs, f_vs, f_blank_n, f_rgb); end
    reset = 1'b0;
  endtask

  task automatic test_full_timing();
    wait_full(PIPE - 1);
    n_cmp++; if (f_blank_n !== 1'b0) begin n_fail++; $display("FAIL full_blank_pre: got %b want 0", f_blank_n); end
    wait_full(PIPE);
    n_cmp++; if (f_blank_n !== 1'b1) begin n_fail++; $display("FAIL full_blank_rise: got %b want 1", f_blank_n); end
    n_cmp++; if (f_vclk !== 1'b0) begin n_fail++; $display("FAIL full_vga_clk: got %b want 0", f_vclk); end
    wait_full(1279 + PIPE);
    n_cmp++; if (f_blank_n !== 1'b1) begin n_fail++; $display("FAIL full_blank_last: got %b want 1", f_blank_n); end
    wait_full(1280 + PIPE);
    n_cmp++; if (f_blank_n !== 1'b0) begin n_fail++; $display("FAIL full_blank_fall: got %b want 0", f_blank_n); end
    wait_full(1311 + PIPE);
    n_cmp++; if (f_hs !== 1'b1) begin n_fail++; $display("FAIL full_hs_pre: got %b want 1", f_hs); end
    wait_full(1312 + PIPE);
    n_cmp++; if (f_hs !== 1'b0) begin n_fail++; $display("FAIL full_hs_fall: got %b want 0", f_hs); end
    wait_full(1503 + PIPE);
    n_cmp++; if (f_hs !== 1'b0) begin n_fail++; $display("FAIL full_hs_last: got %b want 0", f_hs); end
    wait_full(1504 + PIPE);
    n_cmp++; if (f_hs !== 1'b1) begin n_fail++; $display("FAIL full_hs_rise: got %b want 1", f_hs); end
  endtask

  task automatic test_single_ball();
    set_ball(0, 20, 24, 5, 24'hFF0000, 1'b1);
    wait_pixel(20, 24);
    n_cmp++; if (rgb !== BG) begin n_fail++; $display("FAIL single_before_copy: got %h want %h", rgb, BG); end
    wait_irq();
    @(negedge clk50);
    n_cmp++; if (irq !== 1'b0) begin n_fail++; $display("FAIL single_irq_width: got %b want 0", irq); end
    wait_pixel(20, 19);
    n_cmp++; if (rgb !== BG) begin n_fail++; $display("FAIL single_top_edge: got %h want %h", rgb, BG); end
    wait_pixel(20, 20);
    n_cmp++; if (rgb !== 24'hFF0000) begin n_fail++; $display("FAIL single_top_in: got %h want FF0000", rgb); end
    wait_pixel(15, 24);
    n_cmp++; if (rgb !== BG) begin n_fail++; $display("FAIL single_left_edge: got %h want %h", rgb, BG); end
    wait_pixel(16, 24);
    n_cmp++; if (rgb !== 24'hFF0000) begin n_fail++; $display("FAIL single_left_in: got %h want FF0000", rgb); end
    wait_pixel(20, 24);
    n_cmp++; if (rgb !== 24'hFF0000) begin n_fail++; $display("FAIL single_center: got %h want FF0000", rgb); end
    wait_pixel(24, 24);
    n_cmp++; if (rgb !== 24'hFF0000) begin n_fail++; $display("FAIL single_right_in: got %h want FF0000", rgb); end
    wait_pixel(25, 24);
    n_cmp++; if (rgb !== BG) begin n_fail++; $display("FAIL single_right_edge: got %h want %h", rgb, BG); end
  endtask

  task automatic test_priority();
    set_ball(0, 10, 10, 6, 24'h00FF00, 1'b1);
    set_ball(1, 10, 10, 6, 24'h0000FF, 1'b1);
    wait_irq();
    @(negedge clk50);
    write_reg(0, 3, 32'd0);
    wait_pixel(10, 10);
    n_cmp++; if (rgb !== 24'h00FF00) begin n_fail++; $display("FAIL prio_low_index: got %h want 00FF00", rgb); end
    wait_irq();
    wait_pixel(10, 10);
    n_cmp++; if (rgb !== 24'h0000FF) begin n_fail++; $display("FAIL prio_after_disable: got %h want 0000FF", rgb); end
    wait_pixel(16, 10);
    n_cmp++; if (rgb !== BG) begin n_fail++; $display("FAIL prio_radius_edge: got %h want %h", rgb, BG); end
  endtask

  task automatic test_copy_cycle();
    wait_irq();
    write_reg(1, 1, 32'd2);
    n_cmp++; if (irq !== 1'b0) begin n_fail++; $display("FAIL copy_irq_width: got %b want 0", irq); end
    wait_pixel(13, 10);
    n_cmp++; if (rgb !== 24'h0000FF) begin n_fail++; $display("FAIL copy_old_radius: got %h want 0000FF", rgb); end
    wait_irq();
    wait_pixel(11, 10);
    n_cmp++; if (rgb !== 24'h0000FF) begin n_fail++; $display("FAIL copy_new_in: got %h want 0000FF", rgb); end
    wait_pixel(12, 10);
    n_cmp++; if (rgb !== BG) begin n_fail++; $display("FAIL copy_new_edge: got %h want %h", rgb, BG); end
  endtask

  task automatic test_edges();
    set_ball(1, 39, 47, 5, 24'hFF00FF, 1'b1);
    set_ball(2, 0, 0, 5, 24'h00FFFF, 1'b1);
    set_ball(0, 45, 24, 8, 24'hFFFFFF, 1'b1);
    set_ball(3, 20, 24, 10, 24'h123456, 1'b1);
    wait_irq();
    wait_pixel(0, 0);
    n_cmp++; if (rgb !== 24'h00FFFF) begin n_fail++; $display("FAIL edge_origin: got %h want 00FFFF", rgb); end
    wait_pixel(4, 0);
    n_cmp++; if (rgb !== 24'h00FFFF) begin n_fail++; $display("FAIL edge_origin_x4: got %h want 00FFFF", rgb); end
    wait_pixel(5, 0);
    n_cmp++; if (rgb !== BG) begin n_fail++; $display("FAIL edge_origin_x5: got %h want %h", rgb, BG); end
    wait_pixel(39, 0);
    n_cmp++; if (rgb !== BG) begin n_fail++; $display("FAIL edge_no_hwrap: got %h want %h", rgb, BG); end
    wait_pixel(0, 4);
    n_cmp++; if (rgb !== 24'h00FFFF) begin n_fail++; $display("FAIL edge_origin_y4: got %h want 00FFFF", rgb); end
    wait_pixel(0, 5);
    n_cmp++; if (rgb !== BG) begin n_fail++; $display("FAIL edge_origin_y5: got %h want %h", rgb, BG); end
    wait_pixel(20, 24);
    n_cmp++; if (rgb !== BG) begin n_fail++; $display("FAIL edge_ignored_ball: got %h want %h", rgb, BG); end
    wait_pixel(39, 24);
    n_cmp++; if (rgb !== 24'hFFFFFF) begin n_fail++; $display("FAIL edge_partial_right: got %h want FFFFFF", rgb); end
    wait_pixel(45, 24);
    n_cmp++; if (rgb !== 24'h0 || blank_n !== 1'b0)
      begin n_fail++; $display("FAIL edge_blank_pixel: rgb=%h blank=%b want 000000 0", rgb, blank_n); end
    wait_pixel(39, 43);
    n_cmp++; if (rgb !== 24'hFF00FF) begin n_fail++; $display("FAIL edge_corner_y43: got %h want FF00FF", rgb); end
    wait_pixel(0, 47);
    n_cmp++; if (rgb !== BG) begin n_fail++; $display("FAIL edge_no_vwrap: got %h want %h", rgb, BG); end
    wait_pixel(34, 47);
    n_cmp++; if (rgb !== BG) begin n_fail++; $display("FAIL edge_corner_x34: got %h want %h", rgb, BG); end
    wait_pixel(35, 47);
    n_cmp++; if (rgb !== 24'hFF00FF) begin n_fail++; $display("FAIL edge_corner_x35: got %h want FF00FF", rgb); end
    wait_pixel(39, 47);
    n_cmp++; if (rgb !== 24'hFF00FF) begin n_fail++; $display("FAIL edge_corner: got %h want FF00FF", rgb); end
  endtask

  task automatic test_pipe_align();
    wait_hv(PIPE - 1, 1);
    n_cmp++; if (blank_n !== 1'b0 || rgb !== 24'h0)
      begin n_fail++; $display("FAIL align_pre: blank=%b rgb=%h want 0 000000", blank_n, rgb); end
    wait_hv(PIPE, 1);
    n_cmp++; if (blank_n !== 1'b1 || rgb !== 24'h00FFFF)
      begin n_fail++; $display("FAIL align_first: blank=%b rgb=%h want 1 00FFFF", blank_n, rgb); end
    n_cmp++; if (vclk !== 1'b0) begin n_fail++; $display("FAIL align_vclk_even: got %b want 0", vclk); end
    wait_hv(HA - 1 + PIPE, 1);
    n_cmp++; if (blank_n !== 1'b1 || vclk !== 1'b1)
      begin n_fail++; $display("FAIL align_last: blank=%b vclk=%b want 1 1", blank_n, vclk); end
    wait_hv(HA + PIPE, 1);
    n_cmp++; if (blank_n !== 1'b0) begin n_fail++; $display("FAIL align_blank_fall: got %b want 0", blank_n); end
    wait_hv(HA + HF - 1 + PIPE, 1);
    n_cmp++; if (hs !== 1'b1) begin n_fail++; $display("FAIL align_hs_pre: got %b want 1", hs); end
    wait_hv(HA + HF + PIPE, 1);
    n_cmp++; if (hs !== 1'b0) begin n_fail++; $display("FAIL align_hs_fall: got %b want 0", hs); end
    wait_hv(HA + HF + HSY - 1 + PIPE, 1);
    n_cmp++; if (hs !== 1'b0) begin n_fail++; $display("FAIL align_hs_last: got %b want 0", hs); end
    wait_hv(HA + HF + HSY + PIPE, 1);
    n_cmp++; if (hs !== 1'b1) begin n_fail++; $display("FAIL align_hs_rise: got %b want 1", hs); end
    wait_hv(0, VA);
    n_cmp++; if (irq !== 1'b1) begin n_fail++; $display("FAIL align_irq_on: got %b want 1", irq); end
    wait_hv(1, VA);
    n_cmp++; if (irq !== 1'b0) begin n_fail++; $display("FAIL align_irq_off: got %b want 0", irq); end
    wait_hv(PIPE - 1, VA + VF);
    n_cmp++; if (vs !== 1'b1) begin n_fail++; $display("FAIL align_vs_pre: got %b want 1", vs); end
    wait_hv(PIPE, VA + VF);
    n_cmp++; if (vs !== 1'b0) begin n_fail++; $display("FAIL align_vs_fall: got %b want 0", vs); end
    wait_hv(PIPE - 1, VA + VF + VSY);
    n_cmp++; if (vs !== 1'b0) begin n_fail++; $display("FAIL align_vs_last: got %b want 0", vs); end
    wait_hv(PIPE, VA + VF + VSY);
    n_cmp++; if (vs !== 1'b1) begin n_fail++; $display("FAIL align_vs_rise: got %b want 1", vs); end
  endtask

  task automatic test_midframe_reset();
    wait_pixel(39, 24);
    n_cmp++; if (rgb !== 24'hFFFFFF) begin n_fail++; $display("FAIL mid_pre_reset: got %h want FFFFFF", rgb); end
    reset = 1'b1;
    #1;
    n_cmp++; if (rgb !== 24'h0 || hs !== 1'b1 || vs !== 1'b1 || blank_n !== 1'b0 || irq !== 1'b0)
      begin n_fail++; $display("FAIL mid_reset_outputs: rgb=%h hs=%b vs=%b blank=%b irq=%b want 000000 1 1 0 0", rgb, hs, vs, blank_n, irq); end
    repeat (3) @(negedge clk50);
    reset = 1'b0;
    wait_hv(2, 0);
    n_cmp++; if (hs !== 1'b1 || vs !== 1'b1 || blank_n !== 1'b0)
      begin n_fail++; $display("FAIL mid_release: hs=%b vs=%b blank=%b want 1 1 0", hs, vs, blank_n); end
    wait_pixel(39, 24);
    n_cmp++; if (rgb !== BG) begin n_fail++; $display("FAIL mid_balls_disabled: got %h want %h", rgb, BG); end
    wait_hv(0, VA);
    n_cmp++; if (irq !== 1'b1) begin n_fail++; $display("FAIL mid_irq: got %b want 1", irq); end
    wait_hv(PIPE - 1, VA + VF);
    n_cmp++; if (vs !== 1'b1) begin n_fail++; $display("FAIL mid_vs_pre: got %b want 1", vs); end
    wait_hv(PIPE, VA + VF);
    n_cmp++; if (vs !== 1'b0) begin n_fail++; $display("FAIL mid_vs_fall: got %b want 0", vs); end
    wait_hv(PIPE, VA + VF + 1);
    n_cmp++; if (vs !== 1'b0) begin n_fail++; $display("FAIL mid_vs_second_line: got %b want 0", vs); end
    wait_hv(PIPE, VA + VF + VSY);
    n_cmp++; if (vs !== 1'b1) begin n_fail++; $display("FAIL mid_vs_rise: got %b want 1", vs); end
  endtask

  initial begin
    test_reset();
    test_full_timing();
    test_single_ball();
    test_priority();
    test_copy_cycle();
    test_edges();
    test_pipe_align();
    test_midframe_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
